// File: rtl/mul_seq_unit.sv
// ---------------------------------------------------------------------------
// mul_seq_unit
//
// Iterative radix-2 shift-add multiplier for the multi-cycle ARM core.
// Computes MUL, UMULL and SMULL (optionally MLA/UMLAL/SMLAL) over WIDTH-bit
// operands, producing a 2*WIDTH-bit product plus {N,Z} flags.
//
// Optional feature macro: MUL_ACCUM_EN
//   defined   -> acc port present; op[2]=1 adds acc to the product in FIX.
//   undefined -> no acc port, no accumulate adder; op[2] is ignored.
//   Timing is the same in both builds.
//
// Ports
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-low reset
//   start      in   1        operation request, sampled only in IDLE
//   op         in   3        [1:0] 00 MUL, 01 UMULL, 10 SMULL, 11 as UMULL;
//                            [2] accumulate
//   a          in   WIDTH    multiplicand (Rn)
//   b          in   WIDTH    multiplier (Rm)
//   acc        in   2*WIDTH  accumulate addend {RdHi,RdLo} (MUL_ACCUM_EN only)
//   busy       out  1        high while an operation is in flight
//   done       out  1        one-cycle pulse when results are valid
//   result_lo  out  WIDTH    product bits [WIDTH-1:0]
//   result_hi  out  WIDTH    product bits [2*WIDTH-1:WIDTH]; 0 for MUL
//   flags      out  2        {N,Z} of the result
//
// Latency: start accepted at edge E0 -> done high in the cycle after
// edge E0+WIDTH+1 (WIDTH+2 cycles); next start accepted no earlier than
// the first cycle back in IDLE.
// ---------------------------------------------------------------------------
module mul_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef MUL_ACCUM_EN
    input  logic [2*WIDTH-1:0]   acc,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result_lo,
    output logic [WIDTH-1:0]     result_hi,
    output logic [1:0]           flags
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // FSM and handshake registers
    state_t          state_r;
    state_t          state_s;
    logic            busy_r;
    logic            busy_s;
    logic            done_r;
    logic            done_s;

    // Datapath registers
    logic [1:0]      op_r;
    logic            sign_r;
    logic [PW-1:0]   mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [PW-1:0]   prod_r;
    logic [CW-1:0]   count_r;
    logic [WIDTH-1:0] result_lo_r;
    logic [WIDTH-1:0] result_hi_r;
    logic [1:0]      flags_r;

    // Operand conditioning
    logic            smull_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;

    // FIX-stage combinational results
    logic [PW-1:0]   prod_fix_s;
    logic [PW-1:0]   sum_s;
    logic [WIDTH-1:0] fix_lo_s;
    logic [WIDTH-1:0] fix_hi_s;
    logic [1:0]      fix_flags_s;

`ifdef MUL_ACCUM_EN
    logic            accum_r;
    logic [PW-1:0]   acc_r;
`else
    // op[2] has no function without the accumulate adder.
    logic            op_unused_s;
    assign op_unused_s = op[2];
`endif

    assign busy      = busy_r;
    assign done      = done_r;
    assign result_lo = result_lo_r;
    assign result_hi = result_hi_r;
    assign flags     = flags_r;

    // Operand magnitudes: SMULL works on |a|*|b| as unsigned WIDTH-bit
    // values, so -2^(W-1) maps to 2^(W-1) without overflow.
    always_comb begin
        smull_s = (op[1:0] == 2'b10);
        if (smull_s && a[WIDTH-1]) begin
            mag_a_s = {WIDTH{1'b0}} - a;
        end else begin
            mag_a_s = a;
        end
        if (smull_s && b[WIDTH-1]) begin
            mag_b_s = {WIDTH{1'b0}} - b;
        end else begin
            mag_b_s = b;
        end
    end

    // Next-state and next-handshake logic; busy/done are registered copies.
    always_comb begin
        state_s = state_r;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_CALC;
                    busy_s  = 1'b1;
                end else begin
                    state_s = S_IDLE;
                    busy_s  = 1'b0;
                end
            end
            S_CALC: begin
                busy_s = 1'b1;
                if (count_r == CW'(1)) begin
                    state_s = S_FIX;
                end else begin
                    state_s = S_CALC;
                end
            end
            S_FIX: begin
                state_s = S_DONE;
                done_s  = 1'b1;
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register with handshake outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // FIX stage: restore sign, optionally accumulate, format and flag.
    always_comb begin
        if (sign_r) begin
            prod_fix_s = {PW{1'b0}} - prod_r;
        end else begin
            prod_fix_s = prod_r;
        end
`ifdef MUL_ACCUM_EN
        if (accum_r) begin
            sum_s = prod_fix_s + acc_r;
        end else begin
            sum_s = prod_fix_s;
        end
`else
        sum_s = prod_fix_s;
`endif
        if (op_r == 2'b00) begin
            // MUL keeps only the low word; flags come from that word alone.
            fix_lo_s    = sum_s[WIDTH-1:0];
            fix_hi_s    = {WIDTH{1'b0}};
            fix_flags_s = {sum_s[WIDTH-1], (sum_s[WIDTH-1:0] == {WIDTH{1'b0}})};
        end else begin
            fix_lo_s    = sum_s[WIDTH-1:0];
            fix_hi_s    = sum_s[PW-1:WIDTH];
            fix_flags_s = {sum_s[PW-1], (sum_s == {PW{1'b0}})};
        end
    end

    // Datapath: operand capture, shift-add iteration and result registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_r        <= 2'b00;
            sign_r      <= 1'b0;
            mcand_r     <= {PW{1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
            prod_r      <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            result_lo_r <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            flags_r     <= 2'b00;
`ifdef MUL_ACCUM_EN
            accum_r     <= 1'b0;
            acc_r       <= {PW{1'b0}};
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        op_r     <= op[1:0];
                        sign_r   <= smull_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                        mcand_r  <= {{WIDTH{1'b0}}, mag_a_s};
                        mplier_r <= mag_b_s;
                        prod_r   <= {PW{1'b0}};
                        count_r  <= CW'(WIDTH);
`ifdef MUL_ACCUM_EN
                        accum_r  <= op[2];
                        acc_r    <= acc;
`endif
                    end
                end
                S_CALC: begin
                    // mcand_r is pre-shifted so it always sits at the
                    // weight of the multiplier bit currently in mplier_r[0].
                    if (mplier_r[0]) begin
                        prod_r <= prod_r + mcand_r;
                    end
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    count_r  <= count_r - CW'(1);
                end
                S_FIX: begin
                    result_lo_r <= fix_lo_s;
                    result_hi_r <= fix_hi_s;
                    flags_r     <= fix_flags_s;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_unit.sv
// Self-checking bench for mul_seq_unit: a 32-bit and an 8-bit instance,
// directed steps, expected results queued at drive time and popped on done.
module tb_mul_seq_unit;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [1:0]  fl;
    } exp_t;

    logic        clk;
    logic        reset;

    logic        start32, busy32, done32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, lo32, hi32;
    logic [63:0] acc32;
    logic [1:0]  flags32;

    logic        start8, busy8, done8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, lo8, hi8;
    logic [15:0] acc8;
    logic [1:0]  flags8;

    int   total;
    int   bad;
    bit   dsel;
    exp_t q[$];

    logic        done_v, busy_v;
    logic [31:0] lo_v, hi_v;
    logic [1:0]  fl_v;

    assign done_v = dsel ? done8  : done32;
    assign busy_v = dsel ? busy8  : busy32;
    assign lo_v   = dsel ? {24'd0, lo8} : lo32;
    assign hi_v   = dsel ? {24'd0, hi8} : hi32;
    assign fl_v   = dsel ? flags8 : flags32;

    mul_seq_unit #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32),
        .a(a32), .b(b32),
`ifdef MUL_ACCUM_EN
        .acc(acc32),
`endif
        .busy(busy32), .done(done32),
        .result_lo(lo32), .result_hi(hi32), .flags(flags32)
    );

    mul_seq_unit #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8),
        .a(a8), .b(b8),
`ifdef MUL_ACCUM_EN
        .acc(acc8),
`endif
        .busy(busy8), .done(done8),
        .result_lo(lo8), .result_hi(hi8), .flags(flags8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent 32-bit reference: full-width integer product of the
    // (sign- or zero-) extended operands.
    function automatic exp_t model32(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [63:0] acc);
        logic [63:0] p;
        exp_t        e;
        if (op[1:0] == 2'b10) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        else                  p = {32'd0, a} * {32'd0, b};
`ifdef MUL_ACCUM_EN
        if (op[2]) p = p + acc;
`else
        if (op[2]) p = p + 64'd0 * acc;
`endif
        e.lo = p[31:0];
        if (op[1:0] == 2'b00) begin
            e.hi = 32'd0;
            e.fl = {p[31], (p[31:0] == 32'd0)};
        end else begin
            e.hi = p[63:32];
            e.fl = {p[63], (p == 64'd0)};
        end
        return e;
    endfunction

    // Drive one request on the selected DUT and queue its expected result.
    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] acc, input exp_t e, input bit hold);
        @(negedge clk);
        if (dsel) begin
            op8 = op; a8 = a[7:0]; b8 = b[7:0]; acc8 = acc[15:0]; start8 = 1'b1;
        end else begin
            op32 = op; a32 = a; b32 = b; acc32 = acc; start32 = 1'b1;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) begin
            start8  = 1'b0;
            start32 = 1'b0;
        end
    endtask

    // Wait (bounded) for done, check latency/busy, pop and compare results.
    // Called just after the accepting edge; negedge k=1 is the first cycle.
    task automatic wait_done(input string tag, input int exp_lat);
        int   k;
        int   busy_n;
        bit   seen;
        exp_t e;
        k = 0; busy_n = 0; seen = 1'b0;
        while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            if (done_v === 1'b1) seen = 1'b1;
            else if (busy_v === 1'b1) busy_n++;
        end
        chk({tag, "/done_seen"}, 64'(seen), 64'd1);
        e = q.pop_front();
        if (seen) begin
            chk({tag, "/latency"}, 64'(k), 64'(exp_lat));
            chk({tag, "/busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
            chk({tag, "/busy_at_done"}, 64'(busy_v), 64'd0);
            chk({tag, "/lo"}, 64'(lo_v), 64'(e.lo));
            chk({tag, "/hi"}, 64'(hi_v), 64'(e.hi));
            chk({tag, "/flags"}, 64'(fl_v), 64'(e.fl));
        end
    endtask

    initial begin
        exp_t        e;
        int          ndone;
        int          at;
        logic [31:0] got_lo, got_hi;
        logic [1:0]  got_fl;

        total = 0; bad = 0; dsel = 1'b0;
        reset = 1'b0;
        start32 = 1'b0; op32 = 3'd0; a32 = 32'd0; b32 = 32'd0; acc32 = 64'd0;
        start8  = 1'b0; op8  = 3'd0; a8  = 8'd0;  b8  = 8'd0;  acc8  = 16'd0;
        got_lo = 32'd0; got_hi = 32'd0; got_fl = 2'b00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst/busy32", 64'(busy32), 64'd0);
        chk("rst/done32", 64'(done32), 64'd0);
        chk("rst/lo32",   64'(lo32),   64'd0);
        chk("rst/hi32",   64'(hi32),   64'd0);
        chk("rst/flags32", 64'(flags32), 64'd0);
        chk("rst/busy8",  64'(busy8),  64'd0);
        chk("rst/done8",  64'(done8),  64'd0);
        reset = 1'b1;

        // MUL 7*6, with latency and hold checks
        drive(3'b000, 32'd7, 32'd6, 64'd0, '{lo: 32'd42, hi: 32'd0, fl: 2'b00}, 1'b0);
        wait_done("mul_7x6", 34);
        @(negedge clk);
        chk("mul_7x6/done_one_cycle", 64'(done32), 64'd0);
        chk("mul_7x6/lo_held", 64'(lo32), 64'd42);

        drive(3'b010, 32'hFFFFFFFD, 32'd5, 64'd0,
              '{lo: 32'hFFFFFFF1, hi: 32'hFFFFFFFF, fl: 2'b10}, 1'b0);
        wait_done("smull_m3x5", 34);

        drive(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0,
              '{lo: 32'h00000001, hi: 32'hFFFFFFFE, fl: 2'b10}, 1'b0);
        wait_done("umull_max", 34);

        drive(3'b000, 32'd0, 32'h1234, 64'd0, '{lo: 32'd0, hi: 32'd0, fl: 2'b01}, 1'b0);
        wait_done("mul_zero", 34);

        drive(3'b010, 32'h80000000, 32'h80000000, 64'd0,
              '{lo: 32'd0, hi: 32'h40000000, fl: 2'b00}, 1'b0);
        wait_done("smull_minmin", 34);

        // Reserved encoding behaves as UMULL (would be hi=FFFFFFFF if signed)
        drive(3'b011, 32'hFFFFFFFF, 32'd2, 64'd0,
              '{lo: 32'hFFFFFFFE, hi: 32'h00000001, fl: 2'b00}, 1'b0);
        wait_done("op11_unsigned", 34);

`ifdef MUL_ACCUM_EN
        drive(3'b101, 32'd2, 32'd3, 64'd10, '{lo: 32'd16, hi: 32'd0, fl: 2'b00}, 1'b0);
        wait_done("umlal_small", 34);
        drive(3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF,
              '{lo: 32'd0, hi: 32'hFFFFFFFE, fl: 2'b10}, 1'b0);
        wait_done("umlal_wrap", 34);
        drive(3'b110, 32'hFFFFFFFD, 32'd5, 64'd20, '{lo: 32'd5, hi: 32'd0, fl: 2'b00}, 1'b0);
        wait_done("smlal", 34);
        drive(3'b100, 32'd7, 32'd6, 64'h1_00000008, '{lo: 32'd50, hi: 32'd0, fl: 2'b00}, 1'b0);
        wait_done("mla_trunc", 34);
`else
        drive(3'b101, 32'd2, 32'd3, 64'd10, '{lo: 32'd6, hi: 32'd0, fl: 2'b00}, 1'b0);
        wait_done("op2_ignored_umull", 34);
        drive(3'b100, 32'd7, 32'd6, 64'd9, '{lo: 32'd42, hi: 32'd0, fl: 2'b00}, 1'b0);
        wait_done("op2_ignored_mul", 34);
`endif

        // start re-pulsed at cycle 10 of a busy operation is ignored
        e = model32(3'b001, 32'hDEADBEEF, 32'h00001000, 64'd0);
        drive(3'b001, 32'hDEADBEEF, 32'h00001000, 64'd0, e, 1'b0);
        ndone = 0; at = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (i == 10) begin
                start32 = 1'b1; op32 = 3'b000; a32 = 32'd1; b32 = 32'd1;
            end
            if (i == 11) start32 = 1'b0;
            if (done32 === 1'b1) begin
                ndone++; at = i; got_lo = lo32; got_hi = hi32; got_fl = flags32;
            end
        end
        e = q.pop_front();
        chk("repulse/done_count", 64'(ndone), 64'd1);
        chk("repulse/latency", 64'(at), 64'd34);
        chk("repulse/lo", 64'(got_lo), 64'(e.lo));
        chk("repulse/hi", 64'(got_hi), 64'(e.hi));
        chk("repulse/flags", 64'(got_fl), 64'(e.fl));

        // Reset at cycle 20 aborts: outputs cleared, no done
        e = model32(3'b010, 32'hFFFF0000, 32'h00012345, 64'd0);
        drive(3'b010, 32'hFFFF0000, 32'h00012345, 64'd0, e, 1'b0);
        ndone = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 20) reset = 1'b0;
            if (i == 21) begin
                reset = 1'b1;
                chk("abort/busy", 64'(busy32), 64'd0);
                chk("abort/lo", 64'(lo32), 64'd0);
                chk("abort/hi", 64'(hi32), 64'd0);
                chk("abort/flags", 64'(flags32), 64'd0);
            end
            if (done32 === 1'b1) ndone++;
        end
        chk("abort/no_done", 64'(ndone), 64'd0);
        e = q.pop_front();  // the aborted request never completes

        e = model32(3'b001, 32'h12345678, 32'h9ABCDEF0, 64'd0);
        drive(3'b001, 32'h12345678, 32'h9ABCDEF0, 64'd0, e, 1'b0);
        wait_done("after_abort", 34);

        // WIDTH=8 instance
        dsel = 1'b1;
        drive(3'b010, 32'h80, 32'h80, 64'd0, '{lo: 32'h00, hi: 32'h40, fl: 2'b00}, 1'b0);
        wait_done("w8_smull_minmin", 10);

        // start held high: ignored in DONE, accepted on the first IDLE cycle
        e = '{lo: 32'h10, hi: 32'h0E, fl: 2'b00};
        drive(3'b001, 32'hF0, 32'h0F, 64'd0, e, 1'b1);
        q.push_back(e);
        wait_done("w8_b2b_first", 10);
        @(negedge clk);
        chk("w8_b2b/idle_done", 64'(done8), 64'd0);
        chk("w8_b2b/idle_busy", 64'(busy8), 64'd0);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_done("w8_b2b_second", 10);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_seq_unit.md
# mul_seq_unit

Parametrised iterative multiply unit for the multi-cycle ARM core. It computes MUL, UMULL and SMULL, with optional accumulate, over a configurable operand width using a radix-2 shift-add datapath. A start/busy/done handshake lets the control FSM hold in a multiply state for a known number of cycles. It generalises the single-cycle opMul/IsLongMul path: any WIDTH, signed and unsigned long products, and NZ flag generation.

## Interface
- WIDTH, 32, operand width in bits (≥4); products are 2*WIDTH bits
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  3  op[1:0]: 00 MUL, 01 UMULL, 10 SMULL, 11 reserved (treated as UMULL); op[2]: accumulate
- a  in  WIDTH  multiplicand (Rn)
- b  in  WIDTH  multiplier (Rm)
- acc  in  2*WIDTH  accumulate addend {RdHi,RdLo}; present only with MUL_ACCUM_EN
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when results are valid
- result_lo  out  WIDTH  product bits [WIDTH-1:0]
- result_hi  out  WIDTH  product bits [2*WIDTH-1:WIDTH]; 0 for MUL
- flags  out  2  {N,Z} of the result

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1: latch op, a, b and acc.
  - SMULL: latch |a| and |b| and record sign = a[W-1]^b[W-1].
  - Otherwise latch a and b unchanged.
  - Clear the 2W-bit accumulator; load count = WIDTH; go to CALC.
- CALC: each cycle, if mplier[0] is 1, add mcand (zero-extended, shifted left by the current bit index) to the accumulator. Shift mplier right; decrement count. When count reaches 1, go to FIX.
- FIX:
  - If sign is set, negate the product (two's complement, 2W bits).
  - With accumulate enabled and op[2]=1, add acc, modulo 2^(2W).
  - Register the outputs:
    - MUL: result_lo = low W bits, result_hi = 0.
    - Long ops: full 2W-bit product.
  - Go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Flags:
  - MUL: N = result_lo[W-1]; Z = (result_lo==0).
  - Long ops: N = result_hi[W-1]; Z = ({hi,lo}==0).
- result_lo, result_hi and flags hold their values until the next FIX.
- start outside IDLE is ignored; there is no queueing.
- Edge case: SMULL of -2^(W-1) by -2^(W-1) gives 2^(2W-2), which is exact because magnitudes are handled as W-bit unsigned values.

## Timing
- Reset (reset=0 at a rising edge): state=IDLE; busy, done, result_lo, result_hi, flags and all internal registers are 0. Reset wins over any other event, including mid-CALC; an aborted operation produces no done.
- Start accepted at edge E0:
  - busy=1 from E0 through E0+WIDTH+1.
  - done=1 in the cycle after edge E0+WIDTH+1, with busy=0 in that same cycle.
  - Total latency: WIDTH+2 cycles (34 for WIDTH=32).
- Results and flags update at the same edge that raises done.
- start=1 in the DONE cycle is ignored. The earliest next acceptance is the first cycle back in IDLE, so back-to-back throughput is one operation per WIDTH+3 cycles.

## Configuration
- MUL_ACCUM_EN defined:
  - The acc port exists.
  - op[2]=1 adds acc in FIX, giving MLA, UMLAL and SMLAL; MLA uses only acc[W-1:0] in effect, because the result is truncated.
- MUL_ACCUM_EN undefined:
  - The acc port and the FIX adder are absent.
  - op[2] is ignored.
  - Timing is identical in both builds.

## Test plan
- WIDTH=32, MUL, a=7, b=6, start at E0 -> done at E0+WIDTH+2 (34 cycles), result_lo=42, result_hi=0, flags=00.
- SMULL, a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1, N=1, Z=0.
- UMULL, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, N=1. MUL with a=0, b=0x1234 -> lo=0, Z=1.
- Start pulsed again at cycle 10 of a busy operation -> ignored, only one done. Reset held low at cycle 20 -> busy=0 and results=0 the next cycle, no done; a fresh start afterwards completes normally.
- MUL_ACCUM_EN, UMLAL, a=2, b=3, acc=10 -> lo=16, hi=0. UMLAL, a=b=0xFFFFFFFF, acc=0xFFFFFFFF_FFFFFFFF -> hi=0xFFFFFFFE, lo=0 (wrap-around).
- WIDTH=8, SMULL, a=0x80, b=0x80 -> hi=0x40, lo=0x00, done 10 cycles after start.
